// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder in front of the
// serial pattern detectors.
package serial_feed_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Accepts parallel words over valid/ready and shifts them out one bit per clock.
// A new word reloads on the last bit of the previous one, so the stream has no gaps.
module serial_bit_feeder
    import serial_feed_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int unsigned      OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] shreg_moved;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             on_last;
    logic             take;

    // State, shift register and bit counter
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, handshake and shift logic
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        on_last     = (state == SHIFT) && (cnt == CNT_LAST);
        din_ready   = !res && ((state == IDLE) || on_last);
        take        = din_valid && din_ready;
        shreg_moved = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

        case (state)
            IDLE: begin
                if (take) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!on_last) begin
                    shreg_nxt = shreg_moved;
                    cnt_nxt   = cnt + CNT_W'(1);
                end else if (take) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                end else begin
                    // Last bit leaves: register drains to all zeros.
                    shreg_nxt = shreg_moved;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from registers only
    always_comb begin
        busy       = (state == SHIFT);
        sout_valid = (state == SHIFT);
        sout_last  = on_last;
        sout       = (state == SHIFT) && shreg[OUT_BIT];
    end

endmodule
